dpe_multiplexer_5to1: RTL and testbench
=======================================

# dpe_multiplexer_5to1

Packet-level 5:1 stream multiplexer at the ingress of the data-plane engine (DPE). It merges the CPU stream and four Ethernet port streams into the single DPE input stream. It arbitrates whole packets round-robin and never interleaves words of different packets. A `pause` input stops new packets from being granted so that control logic can quiesce the DPE, and `is_idle` reports when the block is quiescent.

## Interface

Parameters:
- `DATA_W`, default 128: stream data width in bits.
- `KEEP_W`, default `DATA_W/8`: byte-enable width.

Ports (all streams are the `dpe_if` signal set, flattened; input index 0 = CPU, 1..4 = eth_1..eth_4):
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pause`  in  1  when high, no new packet is granted.
- `is_idle`  out  1  high when no packet is granted.
- `in_tvalid`  in  5  per-input valid.
- `in_tready`  out  5  per-input ready.
- `in_tdata`  in  5×DATA_W  per-input data.
- `in_tkeep`  in  5×KEEP_W  per-input byte enables.
- `in_tlast`  in  5  per-input end of packet.
- `out_tvalid`  out  1  to DPE, valid.
- `out_tready`  in  1  from DPE, ready.
- `out_tdata`  out  DATA_W  to DPE, data.
- `out_tkeep`  out  KEEP_W  to DPE, byte enables.
- `out_tlast`  out  1  to DPE, end of packet.

## Operation

- Two states:
  - IDLE: no input is granted.
  - BUSY(sel): input `sel` owns the output.
- IDLE → BUSY(sel):
  - Occurs at the clock edge where `pause`=0 and any `in_tvalid` is high.
  - `sel` is the first requesting index, searching upward with wrap-around from `last+1`.
  - `last` is the most recently granted index.
- BUSY(sel):
  - `out_tvalid`/`tdata`/`tkeep`/`tlast` are combinational copies of input `sel`.
  - `in_tready[sel]` = `out_tready`; all other `in_tready` bits are 0.
- BUSY → IDLE: at the edge where `out_tvalid & out_tready & out_tlast`. `last` is set to `sel` on that edge.
- Pause:
  - Asserting `pause` mid-packet does not stall or truncate the current packet; it completes.
  - While `pause`=1, IDLE is held regardless of requests.
- `is_idle` = (state == IDLE).
- In IDLE: `out_tvalid`=0, `out_tlast`=0, and all `in_tready`=0. `out_tdata`/`out_tkeep` are driven to 0.
- Data is passed unmodified.
- Inputs must hold their words stable while not accepted (AXI-Stream rules).

## Timing

- Reset (`rst`=0): state IDLE, `last`=4 (so CPU wins first), `is_idle`=1, `out_tvalid`=0, all `in_tready`=0.
- Arbitration costs one cycle: the first word of a packet can be transferred no earlier than the cycle after IDLE sees the request.
- Data path latency is 0 cycles once granted (combinational forwarding).
- After a tlast handshake there is exactly one IDLE bubble cycle before the next grant.
- Throughput is one word per cycle while `out_tready`=1. Backpressure on `out_tready` propagates combinationally to the selected input.
- Simultaneous `pause` rise and tlast handshake: the packet finishes and the block stays IDLE.

## Configuration

- `DPE_MUX_SVA_EN` defined: concurrent assertions are compiled in. They check:
  - the selected input's `tdata`/`tkeep`/`tlast` stay stable while `in_tvalid & !in_tready`;
  - at most one `in_tready` bit is set;
  - no grant occurs while `pause`=1 in IDLE;
  - `out_tvalid`=0 in IDLE.
- `DPE_MUX_SVA_EN` not defined: no assertions are compiled in. Functional RTL is identical either way.

## Structure

- Shared package `dpe_pkg`:
  - `DATA_W` and `KEEP_W` defaults;
  - the input-index constants `DPE_SRC_CPU`=0 and `DPE_SRC_ETH1`..`DPE_SRC_ETH4`=1..4;
  - the state enum {IDLE, BUSY}.
- One sub-module is natural: `dpe_rr_arbiter`. It takes the 5-bit request vector and `last`, and returns a grant index plus a grant-valid flag.
- Everything else lives in the top.

## Test plan

- All five inputs request at once after reset; packets are:
  - CPU 01..06 (6 words);
  - eth_1 0B..0E (4 words);
  - eth_2 15..19 (5 words);
  - eth_3 1F..22 (4 words);
  - eth_4 29..2C (4 words).
  - Required: output order CPU, eth_1, eth_2, eth_3, eth_4, with 6/4/5/4/4 words; tlast only on 06, 0E, 19, 22, 2C; no interleaving.
- `out_tready` low for 1 cycle mid-packet → the held word repeats with no loss or duplication, and the selected input sees `in_tready`=0.
- `pause`=1 raised during the CPU packet → the CPU packet completes, then `is_idle`=1 and no grant while paused. On `pause`=0, eth_1 is granted the next cycle.
- Round-robin order: after eth_2 finishes, with requests on eth_1 and eth_4 → eth_4 is granted first.
- Exactly one IDLE cycle (`is_idle`=1, `out_tvalid`=0) between back-to-back packets.
- Reset asserted mid-packet → outputs go to reset values immediately (asynchronously); after release, CPU has first priority.

Source files
------------

// File: rtl/dpe_multiplexer_5to1_pkg.sv
// -----------------------------------------------------------------------------
// dpe_pkg
// Shared definitions for the DPE ingress multiplexer: default stream widths,
// input-index constants (0 = CPU, 1..4 = Ethernet ports), the arbitration
// state enum and a small modulo-5 index helper used by the arbiter.
// -----------------------------------------------------------------------------
package dpe_pkg;

  localparam int DPE_DATA_W = 128;
  localparam int DPE_KEEP_W = DPE_DATA_W / 8;

  localparam int N_SRC = 5;
  localparam int SRC_W = 3;

  localparam logic [SRC_W-1:0] DPE_SRC_CPU  = 3'd0;
  localparam logic [SRC_W-1:0] DPE_SRC_ETH1 = 3'd1;
  localparam logic [SRC_W-1:0] DPE_SRC_ETH2 = 3'd2;
  localparam logic [SRC_W-1:0] DPE_SRC_ETH3 = 3'd3;
  localparam logic [SRC_W-1:0] DPE_SRC_ETH4 = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dpe_state_e;

  // (base + off) mod N_SRC for base < N_SRC and off <= N_SRC.
  function automatic logic [SRC_W-1:0] src_add(input logic [SRC_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return SRC_W'(s);
  endfunction

endpackage

// File: rtl/dpe_multiplexer_5to1_if.sv
// -----------------------------------------------------------------------------
// dpe_if
// AXI-Stream style signal set of the DPE. N lanes are packed side by side so
// one instance can carry the five ingress streams (N=5) and another the single
// DPE input stream (N=1).
//   master : drives tvalid/tdata/tkeep/tlast, receives tready
//   slave  : receives tvalid/tdata/tkeep/tlast, drives tready
// -----------------------------------------------------------------------------
interface dpe_if
  import dpe_pkg::*;
#(
  parameter int DATA_W = DPE_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int N      = 1
);

  logic [N-1:0]        tvalid;
  logic [N-1:0]        tready;
  logic [N*DATA_W-1:0] tdata;
  logic [N*KEEP_W-1:0] tkeep;
  logic [N-1:0]        tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/dpe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dpe_rr_arbiter
// Purely combinational round-robin pick among the five ingress requests.
// The search starts at last+1 and wraps, so the most recently served input
// has the lowest priority.
//   req     in  5  per-input request (tvalid)
//   last    in  3  most recently granted index
//   gnt_idx out 3  chosen index (meaningful when gnt_vld)
//   gnt_vld out 1  at least one request present
// -----------------------------------------------------------------------------
module dpe_rr_arbiter
  import dpe_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    gnt_idx = last;
    gnt_vld = 1'b0;
    // Walk from lowest to highest priority; the last hit (closest to
    // last+1) overrides earlier ones.
    for (int k = N_SRC; k >= 1; k--) begin
      if (req[src_add(last, k)]) begin
        gnt_idx = src_add(last, k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpe_multiplexer_5to1.sv
// -----------------------------------------------------------------------------
// dpe_multiplexer_5to1
// Packet-level 5:1 stream multiplexer at the DPE ingress. Whole packets are
// granted round-robin (CPU = 0, eth_1..eth_4 = 1..4) and never interleaved.
// A grant costs one IDLE cycle; once granted the selected stream is forwarded
// combinationally, including backpressure. `pause` blocks new grants only.
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-low reset
//   pause     in   no new packet is granted while high
//   is_idle   out  high while no packet is granted
//   in_s      dpe_if.slave  (N=5) ingress streams
//   out_m     dpe_if.master (N=1) stream to the DPE
// Build option: define DPE_MUX_SVA_EN to compile in protocol assertions.
// -----------------------------------------------------------------------------
module dpe_multiplexer_5to1
  import dpe_pkg::*;
#(
  parameter int DATA_W = DPE_DATA_W,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pause,
  output logic  is_idle,
  dpe_if.slave  in_s,
  dpe_if.master out_m
);

  dpe_state_e       state_q, state_d;
  logic [SRC_W-1:0] sel_q, sel_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic             is_idle_q, is_idle_d;

  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             eop_hs;

  dpe_rr_arbiter u_arb (
    .req     (in_s.tvalid),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Forwarding path: zero latency, all-zero outputs while IDLE.
  always_comb begin
    out_m.tvalid = '0;
    out_m.tdata  = '0;
    out_m.tkeep  = '0;
    out_m.tlast  = '0;
    in_s.tready  = '0;
    if (state_q == BUSY) begin
      out_m.tvalid       = in_s.tvalid[sel_q];
      out_m.tdata        = in_s.tdata[int'(sel_q)*DATA_W +: DATA_W];
      out_m.tkeep        = in_s.tkeep[int'(sel_q)*KEEP_W +: KEEP_W];
      out_m.tlast        = in_s.tlast[sel_q];
      in_s.tready[sel_q] = out_m.tready[0];
    end
  end

  // End-of-packet handshake on the selected lane.
  always_comb begin
    eop_hs = (state_q == BUSY) && in_s.tvalid[sel_q] && in_s.tlast[sel_q]
             && out_m.tready[0];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (!pause && gnt_vld) begin
          state_d = BUSY;
          sel_d   = gnt_idx;
        end
      end
      BUSY: begin
        // pause is ignored here: a started packet always completes.
        if (eop_hs) begin
          state_d = IDLE;
          last_d  = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
    is_idle_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= DPE_SRC_CPU;
      last_q    <= DPE_SRC_ETH4;   // CPU wins the first arbitration
      is_idle_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      is_idle_q <= is_idle_d;
    end
  end

  assign is_idle = is_idle_q;

`ifdef DPE_MUX_SVA_EN
  a_sel_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == BUSY && in_s.tvalid[sel_q] && !in_s.tready[sel_q]) |=>
      $stable({in_s.tdata[int'(sel_q)*DATA_W +: DATA_W],
               in_s.tkeep[int'(sel_q)*KEEP_W +: KEEP_W],
               in_s.tlast[sel_q]}));

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(in_s.tready));

  a_pause_hold: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE && pause) |=> (state_q == IDLE));

  a_idle_no_valid: assert property (@(posedge clk) disable iff (!rst)
    (state_q == IDLE) |-> !out_m.tvalid[0]);
`endif

endmodule

// File: tb/tb_dpe_multiplexer_5to1.sv
// -----------------------------------------------------------------------------
// tb_dpe_multiplexer_5to1
// Per-input source queues feed the DUT; every word loaded is also pushed to a
// scoreboard in the order the DPE must see it. A single engine process drives
// inputs on the falling edge and compares each output handshake against the
// scoreboard head. Scenario tasks add their own cycle-level checks.
// -----------------------------------------------------------------------------
module tb_dpe_multiplexer_5to1;
  import dpe_pkg::*;

  localparam int DATA_W = DPE_DATA_W;
  localparam int KEEP_W = DPE_KEEP_W;

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  beat_t src_q [N_SRC][$];
  beat_t sb_q  [$];

  logic clk;
  logic rst;
  logic pause;
  logic is_idle;
  logic tb_out_ready = 1'b1;
  logic tb_pause     = 1'b0;
  logic [N_SRC-1:0] hs;

  int n_cmp = 0;
  int n_err = 0;

  dpe_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .N(N_SRC)) in_if ();
  dpe_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .N(1))     out_if ();

  dpe_multiplexer_5to1 #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .pause   (pause),
    .is_idle (is_idle),
    .in_s    (in_if.slave),
    .out_m   (out_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source drivers and output monitor.
  initial begin : engine
    beat_t exp;
    int    act_src;
    hs = '0;
    in_if.tvalid = '0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = '0;
    out_if.tready = 1'b1;
    pause = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_SRC; i++)
        if (rst && hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N_SRC; i++) begin
        if (src_q[i].size() > 0) begin
          in_if.tvalid[i]                   = 1'b1;
          in_if.tdata[i*DATA_W +: DATA_W]   = src_q[i][0].data;
          in_if.tkeep[i*KEEP_W +: KEEP_W]   = src_q[i][0].keep;
          in_if.tlast[i]                    = src_q[i][0].last;
        end else begin
          in_if.tvalid[i]                   = 1'b0;
          in_if.tdata[i*DATA_W +: DATA_W]   = '0;
          in_if.tkeep[i*KEEP_W +: KEEP_W]   = '0;
          in_if.tlast[i]                    = 1'b0;
        end
      end
      out_if.tready = tb_out_ready;
      pause         = tb_pause;
      #1;
      hs = in_if.tvalid & in_if.tready;
      if (out_if.tvalid[0] && out_if.tready[0]) begin
        act_src = -1;
        for (int i = 0; i < N_SRC; i++) if (in_if.tready[i]) act_src = i;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got src %0d data %h, expected no word", act_src, out_if.tdata);
        end else begin
          exp = sb_q.pop_front();
          if (out_if.tdata !== exp.data || out_if.tkeep !== exp.keep ||
              out_if.tlast[0] !== exp.last || act_src != int'(exp.src)) begin
            n_err++;
            $display("FAIL out_word: got src %0d data %h keep %h last %b, expected src %0d data %h keep %h last %b",
                     act_src, out_if.tdata, out_if.tkeep, out_if.tlast[0],
                     exp.src, exp.data, exp.keep, exp.last);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [DATA_W-1:0] word(input logic [7:0] b);
    return {(DATA_W/8){b}};
  endfunction

  task automatic load_pkt(input int src, input logic [7:0] first, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src  = SRC_W'(src);
      b.data = word(first + 8'(k));
      b.keep = (k == n - 1) ? {1'b0, {(KEEP_W-1){1'b1}}} : '1;
      b.last = (k == n - 1);
      src_q[src].push_back(b);
      sb_q.push_back(b);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N_SRC; i++) src_q[i].delete();
    sb_q.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 1'b0;
    bit srcs_empty;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      srcs_empty = 1'b1;
      for (int i = 0; i < N_SRC; i++) if (src_q[i].size() != 0) srcs_empty = 1'b0;
      if (sb_q.size() == 0 && srcs_empty && is_idle) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_drain: %0d words still pending after %0d cycles, expected 0", name, sb_q.size(), budget);
      flush();
    end
  endtask

  task automatic wait_busy(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (out_if.tvalid[0]) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_grant: out_tvalid never rose within 20 cycles, expected a grant", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (is_idle !== 1'b1) begin n_err++; $display("FAIL reset_is_idle: got %b expected 1", is_idle); end
    n_cmp++;
    if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid_last: got %b/%b expected 0/0", out_if.tvalid, out_if.tlast);
    end
    n_cmp++;
    if (in_if.tready !== 5'b0) begin n_err++; $display("FAIL reset_in_tready: got %b expected 00000", in_if.tready); end
    n_cmp++;
    if (out_if.tdata !== '0 || out_if.tkeep !== '0) begin
      n_err++; $display("FAIL reset_out_data_keep: got %h/%h expected 0/0", out_if.tdata, out_if.tkeep);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_all_request();
    load_pkt(0, 8'h01, 6);
    load_pkt(1, 8'h0B, 4);
    load_pkt(2, 8'h15, 5);
    load_pkt(3, 8'h1F, 4);
    load_pkt(4, 8'h29, 4);
    wait_done("all_request", 100);
  endtask

  task automatic test_backpressure();
    load_pkt(1, 8'h31, 4);
    wait_busy("backpressure");
    tb_out_ready = 1'b0;
    step();
    n_cmp++;
    if (in_if.tready !== 5'b0) begin n_err++; $display("FAIL bp_in_tready: got %b expected 00000", in_if.tready); end
    n_cmp++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== word(8'h32)) begin
      n_err++; $display("FAIL bp_held_word: got valid %b data %h expected 1 %h", out_if.tvalid, out_if.tdata, word(8'h32));
    end
    tb_out_ready = 1'b1;
    wait_done("backpressure", 40);
  endtask

  task automatic test_round_robin();
    // last = eth_1 here, so eth_2 goes first, then eth_4 ahead of eth_1.
    load_pkt(2, 8'h41, 3);
    load_pkt(4, 8'h51, 2);
    load_pkt(1, 8'h61, 2);
    wait_done("round_robin", 60);
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    load_pkt(3, 8'h71, 3);
    load_pkt(4, 8'h81, 2);
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (out_if.tvalid[0] && out_if.tready[0] && out_if.tlast[0]) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL b2b_eop: no tlast handshake within 20 cycles, expected one"); end
    step();
    n_cmp++;
    if (is_idle !== 1'b1 || out_if.tvalid !== 1'b0) begin
      n_err++; $display("FAIL b2b_bubble: got is_idle %b out_tvalid %b expected 1 0", is_idle, out_if.tvalid);
    end
    step();
    n_cmp++;
    if (is_idle !== 1'b0 || out_if.tvalid !== 1'b1 || out_if.tdata !== word(8'h81)) begin
      n_err++; $display("FAIL b2b_next_grant: got is_idle %b valid %b data %h expected 0 1 %h",
                        is_idle, out_if.tvalid, out_if.tdata, word(8'h81));
    end
    wait_done("back_to_back", 40);
  endtask

  task automatic test_pause();
    bit seen = 1'b0;
    load_pkt(0, 8'h91, 4);
    load_pkt(1, 8'hA1, 2);
    wait_busy("pause");
    tb_pause = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (out_if.tvalid[0] && out_if.tready[0] && out_if.tlast[0]) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL pause_cpu_eop: CPU packet did not complete, expected completion"); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (is_idle !== 1'b1 || out_if.tvalid !== 1'b0) begin
        n_err++; $display("FAIL pause_hold_%0d: got is_idle %b out_tvalid %b expected 1 0", c, is_idle, out_if.tvalid);
      end
    end
    tb_pause = 1'b0;
    step();
    n_cmp++;
    if (is_idle !== 1'b1) begin n_err++; $display("FAIL pause_release_edge: got is_idle %b expected 1", is_idle); end
    step();
    n_cmp++;
    if (is_idle !== 1'b0 || out_if.tdata !== word(8'hA1)) begin
      n_err++; $display("FAIL pause_eth1_grant: got is_idle %b data %h expected 0 %h", is_idle, out_if.tdata, word(8'hA1));
    end
    wait_done("pause", 40);
  endtask

  task automatic test_reset_mid_packet();
    load_pkt(2, 8'hB1, 6);
    wait_busy("reset_mid");
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (is_idle !== 1'b1 || out_if.tvalid !== 1'b0 || in_if.tready !== 5'b0) begin
      n_err++; $display("FAIL reset_async: got is_idle %b out_tvalid %b in_tready %b expected 1 0 00000",
                        is_idle, out_if.tvalid, in_if.tready);
    end
    flush();
    step();
    step();
    rst = 1'b1;
    // Without the reset eth_3 would beat CPU (last was eth_1).
    load_pkt(0, 8'hD1, 2);
    load_pkt(3, 8'hC1, 2);
    wait_done("reset_mid", 40);
  endtask

  initial begin
    test_reset();
    test_all_request();
    test_backpressure();
    test_round_robin();
    test_back_to_back();
    test_pause();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
